numberle_round_controller: RTL
==============================

// Module: numberle_round_controller
// PURPOSE
//  Sequences one Numberle round: latches the secret, assembles keypad digits into a 4-digit guess,
//  scores each submitted guess per digit, counts tries and declares win/lose. Sits between the
//  keypad decoder and the seven-segment/LED drivers.
//  Replaces the try-parity gating of the old combinational scorer with an explicit FSM.
// PARAMETERS
//  DIGITS     4  guess/secret length in nibbles
//  MAX_TRIES  4  guesses allowed per round (1..7)
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  start      in   1   1-cycle pulse: begin new round, sample number
//  number     in   16  secret; nibble i = digit i
//  key_valid  in   1   1-cycle pulse: key_code is valid
//  key_code   in   4   0x0-0x9 digit, 0xC clear, 0xE enter; others ignored
//  guess      out  16  guess being entered or last scored (newest digit in [3:0])
//  digit      out  3   digits entered so far (0..DIGITS)
//  try_count  out  3   guesses scored this round
//  led        out  16  led[15-i] = 1 if digit i matched on last score; led[11:0] = 0
//  message    out  4   0x0 idle, 0x1..0x7 tries used, 0xA win, 0xE lose
//  round_over out  1   high in WIN/LOSE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; secret register 0.
//  States: IDLE, ENTRY, CHECK, SHOW, WIN, LOSE.
//  start (any state): secret <= number; guess, digit, try_count, led <= 0; message <= 0x0; -> ENTRY.
//   start has priority over any same-cycle key.
//  ENTRY:
//   - digit key with digit<DIGITS: guess <= {guess[11:0],key_code}; digit++.
//   - digit key with digit==DIGITS: ignored.
//   - clear: guess <= 0; digit <= 0.
//   - enter with digit==DIGITS: -> CHECK. Enter with fewer digits: ignored.
//  CHECK (exactly 1 cycle; keys ignored):
//   - led[15-i] <= (guess nibble i == secret nibble i).
//   - try_count++.
//   - all match: message 0xA, -> WIN.
//   - else if try_count+1 == MAX_TRIES: message 0xE, -> LOSE.
//   - else: message <= try_count+1, -> SHOW.
//  Latency: enter accepted in cycle N; led/message/try_count valid after edge N+2.
//  SHOW: led, guess, message held.
//   - digit key: guess <= {12'h0,key_code}; digit <= 1; led <= 0; -> ENTRY.
//   - clear: guess, digit, led <= 0; -> ENTRY.
//   - enter: ignored.
//  WIN/LOSE: all outputs held and keys ignored until start; round_over = 1.
//  IDLE: keys ignored; only start leaves.
//  try_count never exceeds MAX_TRIES; no wrap.
//  Secret changes on number mid-round have no effect.
//  reset asserted mid-round: immediate return to reset values, no partial score.
// STRUCTURE
//  Package numberle_pkg:
//   - state enum
//   - key codes KEY_CLEAR=4'hC, KEY_ENTER=4'hE
//   - message codes MSG_IDLE=0, MSG_WIN=4'hA, MSG_LOSE=4'hE
//  Sub-module digit_entry_buffer: shift register + saturating digit counter, with load/clear/push.
//  Scoring compare is inline in the controller.
// TESTING
//  1. reset, start number=16'h1234, keys 1,2,3,4,enter -> led=16'hF000, message=0xA, round_over=1, try_count=1.
//  2. start 16'h1234, guess 1,2,9,9,enter -> led=16'h3000 (digits 2,3 = 1,2 match), message=0x1, state SHOW.
//  3. Four wrong guesses 0000 vs 16'h5678 -> message 1,2,3 then 0xE after 4th; further keys ignored.
//  4. Enter after 3 digits: no score. 5th digit key: ignored. Clear then 4 digits + enter: scores normally.
//  5. In SHOW, key 7 -> guess=16'h0007, digit=1, led=0. start in WIN -> all outputs 0, ENTRY.
//  6. reset pulsed during CHECK cycle -> all outputs 0 next sample, IDLE; try_count not incremented.

Source files
------------

// File: rtl/numberle_pkg.sv
// Shared types and codes for the Numberle round controller.
package numberle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_SHOW  = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    localparam logic [3:0] MSG_IDLE  = 4'h0;
    localparam logic [3:0] MSG_WIN   = 4'hA;
    localparam logic [3:0] MSG_LOSE  = 4'hE;

    function automatic logic is_digit_key(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/numberle_round_controller_digit_entry_buffer.sv
// Guess assembly: shifts keypad digits in from the right and counts them,
// saturating at DIGITS so extra digits are dropped rather than wrapping.
module digit_entry_buffer #(
    parameter int DIGITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic        push,
    input  logic [3:0]  key_code,
    output logic [15:0] guess,
    output logic [2:0]  digit
);

    localparam logic [2:0] DIGITS_W = 3'(DIGITS);

    // Clear wins over load, load over push; pushes stop once the guess is full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            guess <= 16'h0;
            digit <= 3'd0;
        end else if (clear) begin
            guess <= 16'h0;
            digit <= 3'd0;
        end else if (load) begin
            guess <= {12'h0, key_code};
            digit <= 3'd1;
        end else if (push && (digit < DIGITS_W)) begin
            guess <= {guess[11:0], key_code};
            digit <= digit + 3'd1;
        end
    end

endmodule

// File: rtl/numberle_round_controller.sv
// One Numberle round: latch secret, collect a guess, score it, count tries,
// and declare win or lose.
module numberle_round_controller
    import numberle_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] number,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] guess,
    output logic [2:0]  digit,
    output logic [2:0]  try_count,
    output logic [15:0] led,
    output logic [3:0]  message,
    output logic        round_over
);

    localparam logic [2:0] DIGITS_W = 3'(DIGITS);
    localparam logic [2:0] MAX_W    = 3'(MAX_TRIES);

    state_t      state;
    state_t      next_state;
    logic [15:0] secret;

    logic        key_digit;
    logic        key_clear;
    logic        key_enter;
    logic        buf_clear;
    logic        buf_load;
    logic        buf_push;
    logic        do_start;
    logic        do_score;
    logic        led_clear;
    logic [3:0]  match;
    logic        all_match;
    logic [2:0]  try_next;

    assign key_digit = key_valid && is_digit_key(key_code);
    assign key_clear = key_valid && (key_code == KEY_CLEAR);
    assign key_enter = key_valid && (key_code == KEY_ENTER);

    assign match[0]  = (guess[3:0]   == secret[3:0]);
    assign match[1]  = (guess[7:4]   == secret[7:4]);
    assign match[2]  = (guess[11:8]  == secret[11:8]);
    assign match[3]  = (guess[15:12] == secret[15:12]);
    assign all_match = &match;
    assign try_next  = try_count + 3'd1;

    assign round_over = (state == ST_WIN) || (state == ST_LOSE);

    digit_entry_buffer #(.DIGITS(DIGITS)) u_buffer (
        .clock    (clock),
        .reset    (reset),
        .clear    (buf_clear),
        .load     (buf_load),
        .push     (buf_push),
        .key_code (key_code),
        .guess    (guess),
        .digit    (digit)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and per-cycle control strobes; start overrides any key.
    always_comb begin
        next_state = state;
        buf_clear  = 1'b0;
        buf_load   = 1'b0;
        buf_push   = 1'b0;
        do_start   = 1'b0;
        do_score   = 1'b0;
        led_clear  = 1'b0;
        if (start) begin
            next_state = ST_ENTRY;
            buf_clear  = 1'b1;
            do_start   = 1'b1;
        end else begin
            case (state)
                ST_ENTRY: begin
                    if (key_digit) begin
                        buf_push = 1'b1;
                    end else if (key_clear) begin
                        buf_clear = 1'b1;
                    end else if (key_enter && (digit == DIGITS_W)) begin
                        next_state = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    do_score = 1'b1;
                    if (all_match) begin
                        next_state = ST_WIN;
                    end else if (try_next == MAX_W) begin
                        next_state = ST_LOSE;
                    end else begin
                        next_state = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (key_digit) begin
                        buf_load   = 1'b1;
                        led_clear  = 1'b1;
                        next_state = ST_ENTRY;
                    end else if (key_clear) begin
                        buf_clear  = 1'b1;
                        led_clear  = 1'b1;
                        next_state = ST_ENTRY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Secret, score LEDs, try counter and message.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            secret    <= 16'h0;
            try_count <= 3'd0;
            led       <= 16'h0;
            message   <= MSG_IDLE;
        end else if (do_start) begin
            secret    <= number;
            try_count <= 3'd0;
            led       <= 16'h0;
            message   <= MSG_IDLE;
        end else if (do_score) begin
            led       <= {match[0], match[1], match[2], match[3], 12'h0};
            try_count <= try_next;
            if (all_match) begin
                message <= MSG_WIN;
            end else if (try_next == MAX_W) begin
                message <= MSG_LOSE;
            end else begin
                message <= {1'b0, try_next};
            end
        end else if (led_clear) begin
            led <= 16'h0;
        end
    end

endmodule
